mips_cpu_mem_ctrl: RTL and testbench
====================================

# mips_cpu_mem_ctrl

Avalon-MM master bus controller sitting directly downstream of the CPU control state machine. It issues the instruction fetch in the FETCH state and the data load/store in the MEM_ACCESS state. It drives address, byteenable and writedata, and holds requests stable through `waitrequest`. It latches the fetched instruction and the sign/zero-extended load result for the execute and write-back datapath.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `state`  in  4  CPU state: FETCH=0, EXEC=1, MEM_ACCESS=2, WRITE_BACK=3, HALTED=4
- `pc`  in  32  fetch address
- `eff_addr`  in  32  data effective address (base + offset), valid during MEM_ACCESS
- `opcode`  in  6  opcode of the current instruction (from `instr`)
- `rt_data`  in  32  store source register value
- `address`  out  32  Avalon word address, always `{addr[31:2],2'b00}`
- `read`  out  1  Avalon read
- `write`  out  1  Avalon write
- `byteenable`  out  4  Avalon byte lanes (lane k = bits 8k+7:8k, little-endian)
- `writedata`  out  32  store data, replicated into the selected lanes
- `readdata`  in  32  Avalon read data
- `waitrequest`  in  1  Avalon stall
- `instr`  out  32  instruction register
- `load_data`  out  32  extended load result
- `mem_done`  out  1  transaction completes this cycle
- `misaligned`  out  1  sticky alignment fault (see Configuration)

## Operation
- Supported opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. Any other opcode in MEM_ACCESS issues no access.
- `req` = (`state`==FETCH or `state`==MEM_ACCESS with a supported opcode) and !`done_r`.
- `read` = `req` and (FETCH or load).
- `write` = `req` and store.
- Address source is `pc` in FETCH and `eff_addr` in MEM_ACCESS. Let `a` = address source [1:0].
- byteenable rules:
  - Reads: 4'b1111.
  - SB: 1<<a.
  - SH: a[1] ? 4'b1100 : 4'b0011.
  - SW: 4'b1111.
- writedata rules:
  - SB: `{4{rt_data[7:0]}}`.
  - SH: `{2{rt_data[15:0]}}`.
  - SW: `rt_data`.
- Completion: `req` and !`waitrequest`. On the completing edge:
  - FETCH: `instr` <= `readdata`.
  - Load: `load_data` <= extension of the selected lane(s).
  - In both cases `done_r` <= 1.
- Load extension:
  - LB/LBU: byte lane `a`, sign/zero-extended.
  - LH/LHU: halfword `a[1]`, sign/zero-extended.
  - LW: whole word.
- `done_r` clears on any cycle where `state` differs from the previous cycle's `state` (registered `prev_state`). This gives exactly one transaction per state visit.
- `address`, `byteenable`, `writedata`, `read` and `write` are combinational from inputs and `done_r`. They remain stable while `waitrequest` is high because `state`, `pc`, `eff_addr` and `rt_data` are held by the CPU.
- EXEC, WRITE_BACK and HALTED: `read`=`write`=0.
- `instr` and `load_data` are held until the next completing fetch or load.

## Timing
- Reset values: `instr`=0, `load_data`=0, `done_r`=0, `prev_state`=FETCH, `misaligned`=0.
- While `reset` is high: `read`=`write`=0 and `mem_done`=0.
- Zero-wait access: request and completion occur in the same cycle. `instr`/`load_data` are valid the cycle after `mem_done`.
- N wait cycles: `read`/`write` are held high for N+1 cycles. `mem_done` is a single-cycle pulse on the last cycle.
- If the CPU stays in the same state after completion, no re-request is made (`done_r`=1).
- Reset asserted mid-transaction: the request drops the same cycle and registers return to reset values at the edge. Any pending bus read data is ignored.
- `mem_done` is combinational (`req` & !`waitrequest`). The CPU FSM uses `waitrequest` directly and is unaffected.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned cases are LH/LHU/SH with `a[0]`=1, or LW/SW with `a`!=0.
  - On a misaligned access, `read`/`write` are suppressed and `mem_done`=1 for one cycle.
  - `load_data` is unchanged, `done_r` is set, and `misaligned` is set sticky until reset.
  - A FETCH with `pc[1:0]`!=0 is treated the same way (`instr` unchanged).
- `MEM_ALIGN_CHECK_EN` undefined:
  - `misaligned` is tied 0 and no access is suppressed.
  - The low address bits are ignored for word accesses; halfword accesses use only `a[1]`.

## Test plan
- Fetch, pc=0xBFC00004, `waitrequest` high for 2 cycles, readdata=0x8C220008 -> `read` high for 3 cycles, `address`=0xBFC00004, `byteenable`=1111, `mem_done` on cycle 3, `instr`=0x8C220008 next cycle.
- LB with `eff_addr`=0x1003, readdata=0x80FF1234 -> `load_data`=0xFFFFFF80. LBU with the same inputs -> 0x00000080.
- LHU with `eff_addr`=0x1002, readdata=0xBEEF0000 -> `load_data`=0x0000BEEF. LH with the same inputs -> 0xFFFFBEEF.
- SB with `eff_addr`=0x2001, rt_data=0x000000AB -> `write`=1, `address`=0x2000, `byteenable`=0010, `writedata`=0xABABABAB, single transaction, no re-issue while `state` is held.
- Reset asserted during a stalled load -> `read`=0 the same cycle, `load_data`=0 and `done_r`=0 after the edge. The next FETCH issues a fresh read.
- With `MEM_ALIGN_CHECK_EN`: LW with `eff_addr`=0x3002 -> `read`=0, `mem_done`=1 for one cycle, `misaligned`=1 held until reset.

Source files
------------

// File: rtl/mips_cpu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// mips_cpu_mem_ctrl
//
// Avalon-MM master that performs the CPU's instruction fetch (FETCH state) and
// data load/store (MEM_ACCESS state). Exactly one bus transaction is issued per
// visit to a state; the request is held on the bus until waitrequest drops.
// The fetched instruction and the extended load result are registered for the
// execute / write-back datapath.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   state[3:0]        CPU state (FETCH=0 EXEC=1 MEM_ACCESS=2 WRITE_BACK=3 HALTED=4)
//   pc[31:0]          fetch address
//   eff_addr[31:0]    data effective address (valid in MEM_ACCESS)
//   opcode[5:0]       opcode of the current instruction
//   rt_data[31:0]     store source register value
//   address[31:0]     Avalon word address
//   read, write       Avalon read / write strobes
//   byteenable[3:0]   Avalon byte lanes (lane k = bits 8k+7:8k)
//   writedata[31:0]   store data replicated into the selected lanes
//   readdata[31:0]    Avalon read data
//   waitrequest       Avalon stall
//   instr[31:0]       instruction register
//   load_data[31:0]   sign/zero-extended load result
//   mem_done          transaction completes this cycle (combinational)
//   misaligned        sticky alignment fault
//
// Configuration
//   MEM_ALIGN_CHECK_EN  when defined, misaligned halfword/word accesses and
//                       fetches from a non-word pc are suppressed, complete in
//                       one cycle without touching instr/load_data, and set the
//                       sticky misaligned flag. When undefined, misaligned is 0
//                       and the low address bits are simply ignored.
// -----------------------------------------------------------------------------
module mips_cpu_mem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  state,
  input  logic [31:0] pc,
  input  logic [31:0] eff_addr,
  input  logic [5:0]  opcode,
  input  logic [31:0] rt_data,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic [31:0] instr,
  output logic [31:0] load_data,
  output logic        mem_done,
  output logic        misaligned
);

  typedef enum logic [3:0] {
    ST_FETCH      = 4'd0,
    ST_EXEC       = 4'd1,
    ST_MEM_ACCESS = 4'd2,
    ST_WRITE_BACK = 4'd3,
    ST_HALTED     = 4'd4
  } cpu_state_e;

  typedef enum logic [5:0] {
    OP_LB  = 6'h20,
    OP_LH  = 6'h21,
    OP_LW  = 6'h23,
    OP_LBU = 6'h24,
    OP_LHU = 6'h25,
    OP_SB  = 6'h28,
    OP_SH  = 6'h29,
    OP_SW  = 6'h2B
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_e;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [3:0]   prev_state;
  logic         done_r;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic         is_fetch;
  logic         is_mem;
  logic         op_load;
  logic         op_store;
  logic         op_unsigned;
  access_size_e op_size;
  logic [31:0]  addr_src;
  logic [1:0]   a;

  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    op_load     = 1'b0;
    op_store    = 1'b0;
    op_unsigned = 1'b0;
    op_size     = SZ_WORD;
    case (opcode)
      OP_LB:  begin op_load  = 1'b1; op_size = SZ_BYTE; end
      OP_LH:  begin op_load  = 1'b1; op_size = SZ_HALF; end
      OP_LW:  begin op_load  = 1'b1; op_size = SZ_WORD; end
      OP_LBU: begin op_load  = 1'b1; op_size = SZ_BYTE; op_unsigned = 1'b1; end
      OP_LHU: begin op_load  = 1'b1; op_size = SZ_HALF; op_unsigned = 1'b1; end
      OP_SB:  begin op_store = 1'b1; op_size = SZ_BYTE; end
      OP_SH:  begin op_store = 1'b1; op_size = SZ_HALF; end
      OP_SW:  begin op_store = 1'b1; op_size = SZ_WORD; end
      default: ;
    endcase
  end

  assign is_fetch = (state == ST_FETCH);
  assign is_mem   = (state == ST_MEM_ACCESS);
  assign addr_src = is_fetch ? pc : eff_addr;
  assign a        = addr_src[1:0];

  // A state change invalidates the previous visit's completion immediately, so
  // a zero-wait access can still complete in the first cycle of the new state.
  logic done_eff;
  assign done_eff = done_r && (state == prev_state);

  logic req;
  assign req = !reset && !done_eff &&
               (is_fetch || (is_mem && (op_load || op_store)));

  // ---------------------------------------------------------------------------
  // Alignment check
  // ---------------------------------------------------------------------------
  logic misalign;

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (is_fetch) begin
      misalign = (a != 2'b00);
    end else if (is_mem) begin
      case (op_size)
        SZ_HALF: misalign = a[0];
        SZ_WORD: misalign = (a != 2'b00);
        default: misalign = 1'b0;
      endcase
    end
  end

  logic misaligned_r;
  assign misaligned = misaligned_r;
`else
  assign misalign   = 1'b0;
  assign misaligned = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Bus request
  // ---------------------------------------------------------------------------
  logic bus_req;
  logic bus_complete;

  assign bus_req      = req && !misalign;
  assign bus_complete = bus_req && !waitrequest;

  assign read     = bus_req && (is_fetch || op_load);
  assign write    = bus_req && is_mem && op_store;
  // A suppressed misaligned access completes on its own, without the bus.
  assign mem_done = req && (misalign || !waitrequest);
  assign address  = {addr_src[31:2], 2'b00};

  always_comb begin
    byteenable = 4'b1111;
    writedata  = rt_data;
    if (is_mem && op_store) begin
      case (op_size)
        SZ_BYTE: begin
          byteenable = 4'b0001 << a;
          writedata  = {4{rt_data[7:0]}};
        end
        SZ_HALF: begin
          byteenable = a[1] ? 4'b1100 : 4'b0011;
          writedata  = {2{rt_data[15:0]}};
        end
        default: begin
          byteenable = 4'b1111;
          writedata  = rt_data;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load lane selection and extension
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    case (a)
      2'd0:    byte_sel = readdata[7:0];
      2'd1:    byte_sel = readdata[15:8];
      2'd2:    byte_sel = readdata[23:16];
      default: byte_sel = readdata[31:24];
    endcase
    half_sel = a[1] ? readdata[31:16] : readdata[15:0];

    case (op_size)
      SZ_BYTE: load_ext = op_unsigned ? {24'h0, byte_sel}
                                      : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = op_unsigned ? {16'h0, half_sel}
                                      : {{16{half_sel[15]}}, half_sel};
      default: load_ext = readdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_state <= ST_FETCH;
      done_r     <= 1'b0;
      instr      <= 32'h0;
      load_data  <= 32'h0;
    end else begin
      prev_state <= state;
      done_r     <= mem_done ? 1'b1 : done_eff;
      if (bus_complete && is_fetch) begin
        instr <= readdata;
      end
      if (bus_complete && is_mem && op_load) begin
        load_data <= load_ext;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_r <= 1'b0;
    end else if (req && misalign) begin
      misaligned_r <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_cpu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for mips_cpu_mem_ctrl: a table of single-access vectors with
// hand-computed bus outputs and register results, plus hand-written sequences
// for wait states, alignment faults and reset during a stalled access.
// -----------------------------------------------------------------------------
module tb_mips_cpu_mem_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0;
  localparam logic [3:0] S_EXEC  = 4'd1;
  localparam logic [3:0] S_MEM   = 4'd2;
  localparam logic [3:0] S_WB    = 4'd3;
  localparam logic [3:0] S_HALT  = 4'd4;

  logic        clk;
  logic        reset;
  logic [3:0]  state;
  logic [31:0] pc;
  logic [31:0] eff_addr;
  logic [5:0]  opcode;
  logic [31:0] rt_data;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] instr;
  logic [31:0] load_data;
  logic        mem_done;
  logic        misaligned;

  mips_cpu_mem_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .pc          (pc),
    .eff_addr    (eff_addr),
    .opcode      (opcode),
    .rt_data     (rt_data),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .instr       (instr),
    .load_data   (load_data),
    .mem_done    (mem_done),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  st;
    logic [31:0] pc;
    logic [31:0] ea;
    logic [5:0]  op;
    logic [31:0] rt;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic        e_rd;
    logic        e_wr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        chk_wd;
    logic        e_done;
    logic [31:0] e_reg;   // expected instr (fetch) or load_data (load)
  } vec_t;

  vec_t vecs[15];

  logic [31:0] exp_instr;
  logic [31:0] exp_ld;

  // Leave the current state for one cycle so the next vector is a fresh visit.
  task automatic new_visit();
    state = S_EXEC;
    waitrequest = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    //         st       pc            ea            op     rt            rd            e_addr        rd wr be     e_wd          cw done e_reg
    vecs[0]  = '{S_FETCH, 32'h00400010, 32'h0,        6'h00, 32'h0,        32'h12345678, 32'h00400010, 1, 0, 4'hF, 32'h0,        0, 1, 32'h12345678};
    vecs[1]  = '{S_MEM,   32'h00400014, 32'h00001003, 6'h20, 32'h0,        32'h80FF1234, 32'h00001000, 1, 0, 4'hF, 32'h0,        0, 1, 32'hFFFFFF80};
    vecs[2]  = '{S_MEM,   32'h00400014, 32'h00001003, 6'h24, 32'h0,        32'h80FF1234, 32'h00001000, 1, 0, 4'hF, 32'h0,        0, 1, 32'h00000080};
    vecs[3]  = '{S_MEM,   32'h00400014, 32'h00001002, 6'h25, 32'h0,        32'hBEEF0000, 32'h00001000, 1, 0, 4'hF, 32'h0,        0, 1, 32'h0000BEEF};
    vecs[4]  = '{S_MEM,   32'h00400014, 32'h00001002, 6'h21, 32'h0,        32'hBEEF0000, 32'h00001000, 1, 0, 4'hF, 32'h0,        0, 1, 32'hFFFFBEEF};
    vecs[5]  = '{S_MEM,   32'h00400014, 32'h00001001, 6'h20, 32'h0,        32'h80FF1234, 32'h00001000, 1, 0, 4'hF, 32'h0,        0, 1, 32'h00000012};
    vecs[6]  = '{S_MEM,   32'h00400014, 32'h00001000, 6'h21, 32'h0,        32'h80FF8234, 32'h00001000, 1, 0, 4'hF, 32'h0,        0, 1, 32'hFFFF8234};
    vecs[7]  = '{S_MEM,   32'h00400014, 32'h00001004, 6'h23, 32'h0,        32'hCAFEF00D, 32'h00001004, 1, 0, 4'hF, 32'h0,        0, 1, 32'hCAFEF00D};
    vecs[8]  = '{S_MEM,   32'h00400014, 32'h00002001, 6'h28, 32'h000000AB, 32'h0,        32'h00002000, 0, 1, 4'h2, 32'hABABABAB, 1, 1, 32'h0};
    vecs[9]  = '{S_MEM,   32'h00400014, 32'h00002002, 6'h29, 32'h1234CDEF, 32'h0,        32'h00002000, 0, 1, 4'hC, 32'hCDEFCDEF, 1, 1, 32'h0};
    vecs[10] = '{S_MEM,   32'h00400014, 32'h00002004, 6'h2B, 32'hDEADBEEF, 32'h0,        32'h00002004, 0, 1, 4'hF, 32'hDEADBEEF, 1, 1, 32'h0};
    vecs[11] = '{S_MEM,   32'h00400014, 32'h00002003, 6'h28, 32'h0000005A, 32'h0,        32'h00002000, 0, 1, 4'h8, 32'h5A5A5A5A, 1, 1, 32'h0};
    vecs[12] = '{S_MEM,   32'h00400014, 32'h00002008, 6'h08, 32'h0,        32'h0,        32'h0,        0, 0, 4'hF, 32'h0,        0, 0, 32'h0};
    vecs[13] = '{S_WB,    32'h00400014, 32'h00002010, 6'h23, 32'h0,        32'h0,        32'h0,        0, 0, 4'hF, 32'h0,        0, 0, 32'h0};
    vecs[14] = '{S_HALT,  32'h00400014, 32'h00002010, 6'h2B, 32'h0,        32'h0,        32'h0,        0, 0, 4'hF, 32'h0,        0, 0, 32'h0};

    exp_instr = 32'h0;
    exp_ld    = 32'h0;

    // ---------------- reset ----------------
    reset = 1'b1; state = S_FETCH; pc = 32'h0; eff_addr = 32'h0; opcode = 6'h0;
    rt_data = 32'h0; readdata = 32'h0; waitrequest = 1'b0;
    #1;
    check("rst_read", {31'h0, read}, 32'h0);
    check("rst_write", {31'h0, write}, 32'h0);
    check("rst_mem_done", {31'h0, mem_done}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", instr, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_misaligned", {31'h0, misaligned}, 32'h0);
    reset = 1'b0;
    state = S_EXEC;
    @(posedge clk); #1;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 15; i++) begin
      new_visit();
      state = vecs[i].st; pc = vecs[i].pc; eff_addr = vecs[i].ea; opcode = vecs[i].op;
      rt_data = vecs[i].rt; readdata = vecs[i].rd; waitrequest = 1'b0;
      #1;
      check($sformatf("v%0d_read", i), {31'h0, read}, {31'h0, vecs[i].e_rd});
      check($sformatf("v%0d_write", i), {31'h0, write}, {31'h0, vecs[i].e_wr});
      check($sformatf("v%0d_mem_done", i), {31'h0, mem_done}, {31'h0, vecs[i].e_done});
      if (vecs[i].e_rd || vecs[i].e_wr) begin
        check($sformatf("v%0d_address", i), address, vecs[i].e_addr);
        check($sformatf("v%0d_byteenable", i), {28'h0, byteenable}, {28'h0, vecs[i].e_be});
      end
      if (vecs[i].chk_wd)
        check($sformatf("v%0d_writedata", i), writedata, vecs[i].e_wd);
      if (vecs[i].st == S_FETCH && vecs[i].e_done) exp_instr = vecs[i].e_reg;
      if (vecs[i].st == S_MEM && vecs[i].e_rd)     exp_ld    = vecs[i].e_reg;
      @(posedge clk); #1;
      check($sformatf("v%0d_instr", i), instr, exp_instr);
      check($sformatf("v%0d_load_data", i), load_data, exp_ld);
      // State is still held: no second transaction.
      check($sformatf("v%0d_reissue", i), {30'h0, read, write}, 32'h0);
      check($sformatf("v%0d_done_hold", i), {31'h0, mem_done}, 32'h0);
    end

    // ---------------- fetch with two wait cycles ----------------
    new_visit();
    state = S_FETCH; pc = 32'hBFC00004; readdata = 32'h8C220008;
    for (int c = 0; c < 3; c++) begin
      waitrequest = (c < 2);
      #1;
      check($sformatf("wait_c%0d_read", c), {31'h0, read}, 32'h1);
      check($sformatf("wait_c%0d_address", c), address, 32'hBFC00004);
      check($sformatf("wait_c%0d_be", c), {28'h0, byteenable}, 32'hF);
      check($sformatf("wait_c%0d_mem_done", c), {31'h0, mem_done}, (c == 2) ? 32'h1 : 32'h0);
      if (c < 2) check($sformatf("wait_c%0d_instr_held", c), instr, exp_instr);
      @(posedge clk); #1;
    end
    exp_instr = 32'h8C220008;
    check("wait_instr", instr, exp_instr);
    check("wait_no_reissue", {31'h0, read}, 32'h0);
    check("wait_done_pulse", {31'h0, mem_done}, 32'h0);

    // ---------------- misaligned word load ----------------
    new_visit();
    state = S_MEM; opcode = 6'h23; eff_addr = 32'h00003002; readdata = 32'h77777777;
    waitrequest = 1'b0;
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_read", {31'h0, read}, 32'h0);
    check("mis_mem_done", {31'h0, mem_done}, 32'h1);
    @(posedge clk); #1;
    check("mis_done_once", {31'h0, mem_done}, 32'h0);
    check("mis_flag", {31'h0, misaligned}, 32'h1);
    check("mis_load_data", load_data, exp_ld);
    new_visit();
    check("mis_sticky", {31'h0, misaligned}, 32'h1);
`else
    check("mis_read", {31'h0, read}, 32'h1);
    check("mis_address", address, 32'h00003000);
    check("mis_mem_done", {31'h0, mem_done}, 32'h1);
    @(posedge clk); #1;
    exp_ld = 32'h77777777;
    check("mis_load_data", load_data, exp_ld);
    check("mis_flag", {31'h0, misaligned}, 32'h0);
`endif

    // ---------------- reset during a stalled load ----------------
    new_visit();
    state = S_MEM; opcode = 6'h23; eff_addr = 32'h00001008; readdata = 32'h55555555;
    waitrequest = 1'b1;
    #1;
    check("rmid_read0", {31'h0, read}, 32'h1);
    check("rmid_done0", {31'h0, mem_done}, 32'h0);
    @(posedge clk); #1;
    check("rmid_read1", {31'h0, read}, 32'h1);
    reset = 1'b1;
    #1;
    check("rmid_read_drop", {31'h0, read}, 32'h0);
    check("rmid_done_drop", {31'h0, mem_done}, 32'h0);
    @(posedge clk); #1;
    check("rmid_load_data", load_data, 32'h0);
    check("rmid_instr", instr, 32'h0);
    check("rmid_misaligned", {31'h0, misaligned}, 32'h0);
    reset = 1'b0; waitrequest = 1'b0;
    state = S_FETCH; pc = 32'h00000100; readdata = 32'h11112222;
    #1;
    check("rmid_fetch_read", {31'h0, read}, 32'h1);
    check("rmid_fetch_done", {31'h0, mem_done}, 32'h1);
    @(posedge clk); #1;
    check("rmid_fetch_instr", instr, 32'h11112222);
    check("rmid_fetch_no_reissue", {31'h0, read}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
